// File: rtl/cru_pkg.sv
// cru_pkg -- shared constants for the TI CRU bit bank.
//   CRU_PREFIX   : value addr[0:3] must carry for a CRU bank access
//   CRU_IDX_W    : width of the bit index field addr[8:14]
//   CRU_MAX_BITS : largest bank the index field can address
package cru_pkg;

  localparam logic [3:0] CRU_PREFIX   = 4'b0001;
  localparam int         CRU_IDX_W    = 7;
  localparam int         CRU_MAX_BITS = 128;

endpackage

// File: rtl/cru_bank_if.sv
// cru_bank_if -- TI CPU side of the CRU bus as seen by a CRU bit bank.
//   ti_cru_clk   : CRU write strobe, active low, asynchronous to clk
//   ti_memen     : high when the bus cycle is not a memory cycle
//   addr[0:14]   : TI address bus, addr[0] is the most significant bit
//   ti_cru_out   : CRU write data from the CPU
//   ti_cru_in    : CRU read data to the CPU
//   ti_cru_in_oe : drive enable for ti_cru_in (tri-state lives at the top)
// Modports: master = CPU / bus model, slave = CRU bank.
interface cru_bank_if;

  logic        ti_cru_clk;
  logic        ti_memen;
  logic [0:14] addr;
  logic        ti_cru_out;
  logic        ti_cru_in;
  logic        ti_cru_in_oe;

  modport master (
    output ti_cru_clk, ti_memen, addr, ti_cru_out,
    input  ti_cru_in, ti_cru_in_oe
  );

  modport slave (
    input  ti_cru_clk, ti_memen, addr, ti_cru_out,
    output ti_cru_in, ti_cru_in_oe
  );

endinterface

// File: rtl/cru_sync_edge.sv
// cru_sync_edge -- three-flop synchronizer plus falling-edge detector for
// an asynchronous active-low strobe.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   async_i : asynchronous input (idle high)
//   fall_o  : one-clk pulse per high-to-low transition of async_i
module cru_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  // live_q: s1_q holds a real sample of async_i (not its reset value).
  // armed_q: a real high level has entered the chain since reset, so any
  // high seen in s3_q from now on came from the input. This keeps a strobe
  // that is already low when reset releases from looking like a new edge.
  logic live_q, armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      live_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      live_q  <= 1'b1;
      armed_q <= armed_q | (live_q & s1_q);
    end
  end

  assign fall_o = s3_q & ~s2_q & armed_q;

endmodule

// File: rtl/cru_bank.sv
// cru_bank -- bank of NBITS CRU output bits on the TI CRU bus.
//   clk, reset    : system clock, synchronous active-high reset
//   cru_base      : bank select, compared with addr[4:7]
//   bus           : TI CRU bus (slave modport of cru_bank_if)
//   status_in     : external status returned for READBACK_MASK bits
//   bits          : current latched bit values
//   bit_wr        : one-clk pulse on each accepted write
//   bit_wr_idx    : index of the last accepted write
// Parameters: PULSE_MASK bits auto-clear after PULSE_LEN clks;
// READBACK_MASK bits read back status_in instead of the latch.
module cru_bank
  import cru_pkg::*;
#(
  parameter int               NBITS         = 8,
  parameter logic [NBITS-1:0] PULSE_MASK    = '0,
  parameter int               PULSE_LEN     = 4,
  parameter logic [NBITS-1:0] READBACK_MASK = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cru_base,
  cru_bank_if.slave            bus,
  input  logic [NBITS-1:0]     status_in,
  output logic [NBITS-1:0]     bits,
  output logic                 bit_wr,
  output logic [CRU_IDX_W-1:0] bit_wr_idx
);

  localparam logic [7:0] PULSE_LEN_C = 8'(PULSE_LEN);

  logic [3:0]           addr_pfx;
  logic [3:0]           addr_base;
  logic [CRU_IDX_W-1:0] addr_idx;
  logic                 match;
  logic                 strobe;
  logic                 wr_fire;

  logic [NBITS-1:0]     bits_q, bits_d;
  logic                 bit_wr_q;
  logic [CRU_IDX_W-1:0] bit_wr_idx_q;
  logic                 cru_in_q, cru_in_d;
  logic                 cru_in_oe_q;
  logic [NBITS-1:0]     rd_vec;

  // addr is declared [0:14]; these slices keep addr[0] as the MSB.
  assign addr_pfx  = bus.addr[0:3];
  assign addr_base = bus.addr[4:7];
  assign addr_idx  = bus.addr[8:14];

  assign match = (addr_pfx == CRU_PREFIX) && (addr_base == cru_base) &&
                 (32'(addr_idx) < NBITS);

  cru_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.ti_cru_clk),
    .fall_o  (strobe)
  );

  // The address and data are held stable by the CPU while ti_cru_clk is
  // low, so they can be sampled directly on the synchronized strobe edge.
  assign wr_fire = strobe & match;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_bit
      logic hit;
      assign hit = wr_fire && (addr_idx == CRU_IDX_W'(gi));

      if (PULSE_MASK[gi]) begin : g_pulse
        logic [7:0] cnt_q, cnt_d;
        logic       bit_nx;

        // A write always wins over expiry; writing 0 kills the pulse.
        always_comb begin
          bit_nx = bits_q[gi];
          cnt_d  = cnt_q;
          if (hit) begin
            bit_nx = bus.ti_cru_out;
            cnt_d  = bus.ti_cru_out ? PULSE_LEN_C : 8'd0;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              bit_nx = 1'b0;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_q <= 8'd0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        assign bits_d[gi] = bit_nx;
      end else begin : g_level
        assign bits_d[gi] = hit ? bus.ti_cru_out : bits_q[gi];
      end
    end
  endgenerate

  // Per-bit read source: status for readback bits, latch for the rest.
  assign rd_vec = (READBACK_MASK & status_in) | (~READBACK_MASK & bits_q);

  always_comb begin
    cru_in_d = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      if (addr_idx == CRU_IDX_W'(i)) begin
        cru_in_d = rd_vec[i];
      end
    end
    if (!match) begin
      cru_in_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q       <= '0;
      bit_wr_q     <= 1'b0;
      bit_wr_idx_q <= '0;
      cru_in_q     <= 1'b0;
      cru_in_oe_q  <= 1'b0;
    end else begin
      bits_q      <= bits_d;
      bit_wr_q    <= wr_fire;
      cru_in_q    <= cru_in_d;
      cru_in_oe_q <= bus.ti_memen & match;
      if (wr_fire) begin
        bit_wr_idx_q <= addr_idx;
      end
    end
  end

  assign bits             = bits_q;
  assign bit_wr           = bit_wr_q;
  assign bit_wr_idx       = bit_wr_idx_q;
  assign bus.ti_cru_in    = cru_in_q;
  assign bus.ti_cru_in_oe = cru_in_oe_q;

endmodule

// File: tb/tb_cru_bank.sv
// tb_cru_bank -- directed, table-driven bench for cru_bank
// (NBITS=8, base 2, bit 2 pulse mode with length 4, bit 7 readback).
module tb_cru_bank;

  logic       clk;
  logic       reset;
  logic [3:0] cru_base;
  logic [7:0] status_in;
  logic [7:0] bits;
  logic       bit_wr;
  logic [6:0] bit_wr_idx;

  cru_bank_if bus_if ();

  cru_bank #(
    .NBITS         (8),
    .PULSE_MASK    (8'h04),
    .PULSE_LEN     (4),
    .READBACK_MASK (8'h80)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cru_base   (cru_base),
    .bus        (bus_if),
    .status_in  (status_in),
    .bits       (bits),
    .bit_wr     (bit_wr),
    .bit_wr_idx (bit_wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr = 0;
  int wr_start = 0;

  // Counts clk edges and bit_wr pulses (value from the previous edge).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bit_wr) begin
      wr_cnt  = wr_cnt + 1;
      last_wr = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CRU write: strobe low for 4 clks, then 4 idle clks.
  task automatic do_write(input logic [3:0] pfx, input logic [3:0] base,
                          input logic [6:0] idx, input logic dat, input logic memen);
    @(negedge clk);
    bus_if.addr       = {pfx, base, idx};
    bus_if.ti_cru_out = dat;
    bus_if.ti_memen   = memen;
    bus_if.ti_cru_clk = 1'b0;
    wr_start          = cyc;
    repeat (4) @(negedge clk);
    bus_if.ti_cru_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Drives ti_cru_clk/ti_cru_out per clk from bit patterns (index 2) and
  // records how long bits[2] is high.
  task automatic run_pattern(input logic [31:0] clk_pat, input logic [31:0] dat_pat,
                             output int highs, output int first_hi);
    highs    = 0;
    first_hi = -1;
    for (int i = 0; i < 16; i++) begin
      bus_if.ti_cru_clk = clk_pat[i];
      bus_if.ti_cru_out = dat_pat[i];
      @(negedge clk);
      if (bits[2]) begin
        highs++;
        if (first_hi < 0) first_hi = i;
      end
    end
  endtask

  typedef struct {
    bit         is_rd;
    logic [3:0] pfx;
    logic [3:0] base;
    logic [6:0] idx;
    logic       dat;
    logic       memen;
    logic [7:0] status;
    logic [7:0] exp_bits;
    int         exp_wr;
    logic [6:0] exp_idx;
    logic       exp_in;
    logic       exp_oe;
  } vec_t;

  function automatic vec_t mkv(bit rd, logic [3:0] pfx, logic [3:0] base, logic [6:0] idx,
                               logic dat, logic memen, logic [7:0] status, logic [7:0] eb,
                               int ew, logic [6:0] ei, logic ein, logic eoe);
    vec_t v;
    v.is_rd = rd;   v.pfx = pfx;     v.base = base;   v.idx = idx;
    v.dat = dat;    v.memen = memen; v.status = status;
    v.exp_bits = eb; v.exp_wr = ew;  v.exp_idx = ei;
    v.exp_in = ein; v.exp_oe = eoe;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    int wr0, lat, highs, first_hi;
    string nm;

    //            rd pfx   base  idx dat mem status exp_bits wr idx in oe
    vt[0]  = mkv(0, 4'h1, 4'h2, 7'd3, 1, 1, 8'h00, 8'h08, 1, 7'd3, 0, 0); // hit
    vt[1]  = mkv(0, 4'h1, 4'h3, 7'd3, 0, 1, 8'h00, 8'h08, 0, 7'd3, 0, 0); // wrong base
    vt[2]  = mkv(0, 4'h1, 4'h2, 7'd9, 1, 1, 8'h00, 8'h08, 0, 7'd3, 0, 0); // idx >= NBITS
    vt[3]  = mkv(0, 4'h2, 4'h2, 7'd3, 0, 1, 8'h00, 8'h08, 0, 7'd3, 0, 0); // wrong prefix
    vt[4]  = mkv(0, 4'h1, 4'h2, 7'd0, 1, 1, 8'h00, 8'h09, 1, 7'd0, 0, 0);
    vt[5]  = mkv(0, 4'h1, 4'h2, 7'd7, 1, 1, 8'h00, 8'h89, 1, 7'd7, 0, 0);
    vt[6]  = mkv(0, 4'h1, 4'h2, 7'd3, 0, 1, 8'h00, 8'h81, 1, 7'd3, 0, 0);
    vt[7]  = mkv(1, 4'h1, 4'h2, 7'd7, 0, 1, 8'h80, 8'h81, 0, 7'd3, 1, 1); // readback
    vt[8]  = mkv(1, 4'h1, 4'h2, 7'd7, 0, 1, 8'h00, 8'h81, 0, 7'd3, 0, 1); // status, not latch
    vt[9]  = mkv(1, 4'h1, 4'h2, 7'd0, 0, 1, 8'hFF, 8'h81, 0, 7'd3, 1, 1); // latch bit
    vt[10] = mkv(1, 4'h1, 4'h2, 7'd3, 0, 1, 8'hFF, 8'h81, 0, 7'd3, 0, 1);
    vt[11] = mkv(1, 4'h1, 4'h2, 7'd7, 0, 0, 8'h80, 8'h81, 0, 7'd3, 1, 0); // memory cycle
    vt[12] = mkv(1, 4'h1, 4'h2, 7'd9, 0, 1, 8'hFF, 8'h81, 0, 7'd3, 0, 0); // out of range
    vt[13] = mkv(1, 4'h1, 4'h5, 7'd0, 0, 1, 8'hFF, 8'h81, 0, 7'd3, 0, 0); // wrong base
    vt[14] = mkv(0, 4'h1, 4'h2, 7'd1, 1, 0, 8'h00, 8'h83, 1, 7'd1, 0, 0);

    reset             = 1'b1;
    cru_base          = 4'h2;
    status_in         = 8'h00;
    bus_if.ti_cru_clk = 1'b1;
    bus_if.ti_memen   = 1'b1;
    bus_if.addr       = {4'h1, 4'h2, 7'd7};
    bus_if.ti_cru_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bits", 32'(bits), 32'h0);
    chk("rst_bit_wr", 32'(bit_wr), 32'h0);
    chk("rst_bit_wr_idx", 32'(bit_wr_idx), 32'h0);
    chk("rst_cru_in", 32'(bus_if.ti_cru_in), 32'h0);
    chk("rst_cru_in_oe", 32'(bus_if.ti_cru_in_oe), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      wr0 = wr_cnt;
      if (!vt[v].is_rd) begin
        do_write(vt[v].pfx, vt[v].base, vt[v].idx, vt[v].dat, vt[v].memen);
        nm = $sformatf("v%0d_bits", v);   chk(nm, 32'(bits), 32'(vt[v].exp_bits));
        nm = $sformatf("v%0d_wr_cnt", v); chk(nm, 32'(wr_cnt - wr0), 32'(vt[v].exp_wr));
        nm = $sformatf("v%0d_wr_idx", v); chk(nm, 32'(bit_wr_idx), 32'(vt[v].exp_idx));
        if (vt[v].exp_wr == 1) begin
          lat = last_wr - wr_start - 1;
          nm = $sformatf("v%0d_latency_ok", v);
          chk(nm, 32'(lat >= 3 && lat <= 4), 32'h1);
        end
        $display("vec %0d write addr=%h dat=%0d bits=%h bit_wr_idx=%0d", v,
                 {vt[v].pfx, vt[v].base, vt[v].idx}, vt[v].dat, bits, bit_wr_idx);
      end else begin
        @(negedge clk);
        bus_if.addr     = {vt[v].pfx, vt[v].base, vt[v].idx};
        bus_if.ti_memen = vt[v].memen;
        status_in       = vt[v].status;
        @(negedge clk);
        nm = $sformatf("v%0d_cru_in", v); chk(nm, 32'(bus_if.ti_cru_in), 32'(vt[v].exp_in));
        nm = $sformatf("v%0d_cru_oe", v); chk(nm, 32'(bus_if.ti_cru_in_oe), 32'(vt[v].exp_oe));
        nm = $sformatf("v%0d_bits", v);   chk(nm, 32'(bits), 32'(vt[v].exp_bits));
        nm = $sformatf("v%0d_wr_cnt", v); chk(nm, 32'(wr_cnt - wr0), 32'h0);
        $display("vec %0d read addr=%h memen=%0d cru_in=%0d oe=%0d", v,
                 bus_if.addr, vt[v].memen, bus_if.ti_cru_in, bus_if.ti_cru_in_oe);
      end
    end

    // Pulse-mode sequences on bit 2.
    bus_if.addr     = {4'h1, 4'h2, 7'd2};
    bus_if.ti_memen = 1'b1;
    repeat (4) @(negedge clk);

    wr0 = wr_cnt;
    run_pattern(~32'h0000_000F, 32'hFFFF_FFFF, highs, first_hi);
    chk("pulse_len", 32'(highs), 32'd4);
    chk("pulse_start", 32'(first_hi), 32'd2);
    chk("pulse_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    $display("seq pulse: high %0d clks from sample %0d", highs, first_hi);

    wr0 = wr_cnt;
    run_pattern(~32'h0000_003D, 32'hFFFF_FFFF, highs, first_hi);
    chk("retrig_len", 32'(highs), 32'd6);
    chk("retrig_wr_cnt", 32'(wr_cnt - wr0), 32'd2);
    $display("seq retrigger: high %0d clks from sample %0d", highs, first_hi);

    run_pattern(~32'h0000_003D, 32'h0000_0007, highs, first_hi);
    chk("zero_len", 32'(highs), 32'd2);
    chk("zero_start", 32'(first_hi), 32'd2);
    chk("zero_bits", 32'(bits), 32'h83);
    $display("seq write-0: high %0d clks, bits=%h", highs, bits);

    // Reset during an active pulse with the strobe held low.
    do_write(4'h1, 4'h2, 7'd3, 1'b1, 1'b1);
    do_write(4'h1, 4'h2, 7'd4, 1'b1, 1'b1);
    do_write(4'h1, 4'h2, 7'd5, 1'b1, 1'b1);
    do_write(4'h1, 4'h2, 7'd6, 1'b1, 1'b1);
    @(negedge clk);
    bus_if.addr       = {4'h1, 4'h2, 7'd2};
    bus_if.ti_cru_out = 1'b1;
    bus_if.ti_cru_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_bits", 32'(bits), 32'hFF);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bits", 32'(bits), 32'h0);
    chk("mid_rst_bit_wr", 32'(bit_wr), 32'h0);
    chk("mid_rst_bit_wr_idx", 32'(bit_wr_idx), 32'h0);
    chk("mid_rst_cru_in", 32'(bus_if.ti_cru_in), 32'h0);
    chk("mid_rst_cru_in_oe", 32'(bus_if.ti_cru_in_oe), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr0 = wr_cnt;
    repeat (8) @(negedge clk);
    chk("post_rst_bits", 32'(bits), 32'h0);
    chk("post_rst_wr_cnt", 32'(wr_cnt - wr0), 32'h0);
    bus_if.ti_cru_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_wr_cnt", 32'(wr_cnt - wr0), 32'h0);
    $display("seq reset: bits=%h writes after release=%0d", bits, wr_cnt - wr0);
    do_write(4'h1, 4'h2, 7'd2, 1'b1, 1'b1);
    chk("after_rst_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    chk("after_rst_wr_idx", 32'(bit_wr_idx), 32'd2);
    $display("seq next edge: writes=%0d bit_wr_idx=%0d", wr_cnt - wr0, bit_wr_idx);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
